// File: rtl/magic_device_pkg.sv
// Shared constants, width helpers and the refill request type for the magic device prefetcher.
package magic_device_pkg;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_SEL_W    = 12;
  localparam int DEF_CNT_W    = 32;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Level needs one extra bit so that a full queue (level == depth) is representable.
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int chan_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  localparam int DEF_CHAN_W = chan_width(DEF_CHANNELS);

  // Refill request as presented on the fill port, sized for the default configuration.
  typedef struct packed {
    logic [DEF_CHAN_W-1:0] chan;
    logic [DEF_SEL_W-1:0]  sel;
  } fill_req_t;

endpackage

// File: rtl/magic_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
module magic_rr_arbiter
  import magic_device_pkg::*;
#(
  parameter  int CHANNELS = DEF_CHANNELS,
  localparam int CHAN_W   = chan_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CHAN_W-1:0]   ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [CHAN_W-1:0]   grant_idx,
  output logic                grant_valid
);

  always_comb begin
    int cand;
    logic [CHAN_W-1:0] cand_idx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand     = (int'(ptr) + i) % CHANNELS;
      cand_idx = CHAN_W'(cand);
      if (!grant_valid && req[cand_idx]) begin
        grant_valid     = 1'b1;
        grant_idx       = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/magic_device_prefetcher.sv
// Multi-channel prefetching front end for the magic data device: per-channel queues of source
// data, round-robin refill over a valid/ready port, and a saturating underrun counter.
module magic_device_prefetcher
  import magic_device_pkg::*;
#(
  parameter  int CHANNELS = DEF_CHANNELS,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int SEL_W    = DEF_SEL_W,
  parameter  int CNT_W    = DEF_CNT_W,
  localparam int PTR_W    = ptr_width(DEPTH),
  localparam int LVL_W    = lvl_width(DEPTH),
  localparam int CHAN_W   = chan_width(CHANNELS)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [CHANNELS*SEL_W-1:0]  read_select,
  input  logic [CHANNELS-1:0]        read_ready,
  input  logic [CHANNELS-1:0]        flush,
  output logic [CHANNELS-1:0]        read_valid,
  output logic [CHANNELS*DATA_W-1:0] read_data,
  output logic [CHANNELS*LVL_W-1:0]  level,
  output logic                       fill_valid,
  input  logic                       fill_ready,
  output logic [CHAN_W-1:0]          fill_chan,
  output logic [SEL_W-1:0]           fill_sel,
  input  logic [DATA_W-1:0]          fill_data,
  output logic [CNT_W-1:0]           underrun_count
);

  logic [DATA_W-1:0] mem [CHANNELS][DEPTH];
  logic [LVL_W-1:0]  lvl    [CHANNELS];
  logic [PTR_W-1:0]  rd_ptr [CHANNELS];
  logic [PTR_W-1:0]  wr_ptr [CHANNELS];
  logic [CHAN_W-1:0] rr_ptr;

  logic [CHANNELS-1:0] eligible;
  logic [CHANNELS-1:0] pop;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] grant;
  logic [CHAN_W-1:0]   grant_idx;
  logic                grant_valid;
  logic                fill_fire;
  logic [CNT_W:0]      under_add;
  logic [CNT_W:0]      under_sum;

  magic_rr_arbiter #(.CHANNELS(CHANNELS)) u_arbiter (
    .req         (eligible),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign fill_valid = enable && grant_valid;
  assign fill_fire  = fill_valid && fill_ready;
  assign fill_chan  = grant_idx;
  assign fill_sel   = read_select[int'(grant_idx)*SEL_W +: SEL_W];
  assign push       = grant & {CHANNELS{fill_fire}};

  // Head of each queue is shown directly; no bypass from the fill port into an empty queue.
  always_comb begin
    read_valid = '0;
    read_data  = '0;
    level      = '0;
    eligible   = '0;
    pop        = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      read_valid[c]               = (lvl[c] != '0);
      level[c*LVL_W +: LVL_W]     = lvl[c];
      eligible[c]                 = (lvl[c] < LVL_W'(DEPTH)) && !flush[c];
      pop[c]                      = read_valid[c] && read_ready[c];
      if (read_valid[c]) begin
        read_data[c*DATA_W +: DATA_W] = mem[c][rd_ptr[c]];
      end
    end
  end

  always_comb begin
    under_add = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (read_ready[c] && !read_valid[c]) begin
        under_add = under_add + (CNT_W+1)'(1);
      end
    end
    under_sum = {1'b0, underrun_count} + under_add;
  end

  always_ff @(posedge clock) begin
    if (reset && fill_fire) begin
      mem[grant_idx][wr_ptr[grant_idx]] <= fill_data;
    end
  end

  // A flushed channel is never granted, so flush only has to contend with a pop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        lvl[c]    <= '0;
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
      end
      rr_ptr         <= '0;
      underrun_count <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (flush[c]) begin
          lvl[c]    <= '0;
          rd_ptr[c] <= '0;
          wr_ptr[c] <= '0;
        end else begin
          if (push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
          if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
          if (push[c] && !pop[c])      lvl[c] <= lvl[c] + LVL_W'(1);
          else if (!push[c] && pop[c]) lvl[c] <= lvl[c] - LVL_W'(1);
        end
      end
      if (fill_fire) begin
        rr_ptr <= (grant_idx == CHAN_W'(CHANNELS-1)) ? '0 : grant_idx + CHAN_W'(1);
      end
      underrun_count <= under_sum[CNT_W] ? '1 : under_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_magic_device_prefetcher.sv
// Self-checking bench: queue-level reference model compared every cycle, plus directed literal checks.
module tb_magic_device_prefetcher;
  import magic_device_pkg::*;

  localparam int CH = 4;
  localparam int DP = 4;
  localparam int DW = 64;
  localparam int SW = 12;
  localparam int CW = 32;
  localparam int LW = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic            enable;
  logic [CH*SW-1:0] read_select;
  logic [CH-1:0]   read_ready;
  logic [CH-1:0]   flush;
  logic [CH-1:0]   read_valid;
  logic [CH*DW-1:0] read_data;
  logic [CH*LW-1:0] level;
  logic            fill_valid;
  logic            fill_ready;
  logic [1:0]      fill_chan;
  logic [SW-1:0]   fill_sel;
  logic [DW-1:0]   fill_data;
  logic [CW-1:0]   underrun_count;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  logic [DW-1:0] m_q [CH][$];
  int            m_rr = 0;
  logic [CW-1:0] m_under = '0;
  logic [DW-1:0] src_k = '0;
  fill_req_t     m_req;
  int            mg;
  bit            mfv;
  longint        msum;
  logic [CW-1:0] ub;

  magic_device_prefetcher dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .read_select    (read_select),
    .read_ready     (read_ready),
    .flush          (flush),
    .read_valid     (read_valid),
    .read_data      (read_data),
    .level          (level),
    .fill_valid     (fill_valid),
    .fill_ready     (fill_ready),
    .fill_chan      (fill_chan),
    .fill_sel       (fill_sel),
    .fill_data      (fill_data),
    .underrun_count (underrun_count)
  );

  always #5 clock = ~clock;

  // Data source: hands out an incrementing value, advancing on each accepted refill.
  assign fill_data = src_k;
  always @(posedge clock) begin
    if (reset && fill_valid && fill_ready) src_k <= src_k + 1;
  end

  function automatic bit model_fill_valid();
    bit any = 1'b0;
    for (int c = 0; c < CH; c++) if (m_q[c].size() < DP && !flush[c]) any = 1'b1;
    return enable && any;
  endfunction

  function automatic int model_grant();
    for (int i = 0; i < CH; i++) begin
      int c;
      c = (m_rr + i) % CH;
      if (m_q[c].size() < DP && !flush[c]) return c;
    end
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [CH-1:0] rr, input logic [CH-1:0] fl,
                               input logic fr);
    @(posedge clock);
    #2;
    enable     = en;
    read_ready = rr;
    flush      = fl;
    fill_ready = fr;
  endtask

  // Reference model: each channel is a plain FIFO of values; transitions applied at the clock edge.
  always @(posedge clock) begin
    if (!reset) begin
      for (int c = 0; c < CH; c++) m_q[c].delete();
      m_rr    = 0;
      m_under = '0;
    end else begin
      mfv  = model_fill_valid();
      mg   = model_grant();
      msum = longint'(m_under);
      for (int c = 0; c < CH; c++) if (read_ready[c] && m_q[c].size() == 0) msum++;
      m_under = (msum > 64'sd4294967295) ? '1 : CW'(msum);
      for (int c = 0; c < CH; c++) begin
        if (read_ready[c] && m_q[c].size() > 0) void'(m_q[c].pop_front());
        if (flush[c]) m_q[c].delete();
      end
      if (mfv && fill_ready) begin
        m_q[mg].push_back(fill_data);
        m_rr = (mg + 1) % CH;
      end
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      for (int c = 0; c < CH; c++) begin
        checkOutput($sformatf("read_valid[%0d]", c), 64'(read_valid[c]), 64'(m_q[c].size() > 0));
        checkOutput($sformatf("level[%0d]", c), 64'(level[c*LW +: LW]), 64'(m_q[c].size()));
        checkOutput($sformatf("read_data[%0d]", c), read_data[c*DW +: DW],
                    (m_q[c].size() > 0) ? m_q[c][0] : 64'd0);
      end
      checkOutput("fill_valid", 64'(fill_valid), 64'(model_fill_valid()));
      if (model_fill_valid()) begin
        m_req.chan = 2'(model_grant());
        m_req.sel  = read_select[model_grant()*SW +: SW];
        checkOutput("fill_chan_sel", 64'({fill_chan, fill_sel}), 64'(m_req));
      end
      checkOutput("underrun_count", 64'(underrun_count), 64'(m_under));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b0;
    enable      = 1'b0;
    read_ready  = '0;
    flush       = '0;
    fill_ready  = 1'b0;
    read_select = {12'hA33, 12'hA22, 12'hA11, 12'hA00};
    @(posedge clock);
    check_en = 1'b1;
    @(posedge clock);
    #2 reset = 1'b1;

    // Reset state
    @(negedge clock); #1;
    checkOutput("rst_read_valid", 64'(read_valid), 64'd0);
    checkOutput("rst_level", 64'(level), 64'd0);
    checkOutput("rst_read_data", 64'(read_data[DW-1:0]), 64'd0);
    checkOutput("rst_underrun", 64'(underrun_count), 64'd0);
    checkOutput("rst_fill_valid", 64'(fill_valid), 64'd0);

    // Sixteen fills in round-robin order until every queue is full
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock); #1;
      checkOutput($sformatf("t1_fill_valid_%0d", i), 64'(fill_valid), 64'd1);
      checkOutput($sformatf("t1_grant_%0d", i), 64'(fill_chan), 64'(i % 4));
      if (i == 0) checkOutput("t1_fill_sel", 64'(fill_sel), 64'hA00);
    end
    @(negedge clock); #1;
    checkOutput("t1_fill_valid_full", 64'(fill_valid), 64'd0);
    checkOutput("t1_levels_full", 64'(level), 64'h924);

    // Channel 2 returns exactly its own fills in order
    applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clock); #1;
      checkOutput($sformatf("t2_ch2_data_%0d", j), read_data[2*DW +: DW], 64'(2 + 4*j));
    end
    @(negedge clock); #1;
    checkOutput("t2_ch2_empty", 64'(read_valid[2]), 64'd0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
    @(negedge clock); #1;
    checkOutput("t2_underrun", 64'(underrun_count), 64'd1);

    // Steady consumption on channel 0 with the source always ready
    for (int i = 0; i < 24; i++) applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Flush a full channel 1 while popping its head
    applyStimulus(1'b1, 4'b0010, 4'b0010, 1'b1);
    @(negedge clock); #1;
    checkOutput("t4_ch1_level_before", 64'(level[5:3]), 64'd4);
    checkOutput("t4_ch1_head", read_data[1*DW +: DW], 64'd1);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
    @(negedge clock); #1;
    checkOutput("t4_ch1_level_after", 64'(level[5:3]), 64'd0);
    checkOutput("t4_ch1_valid_after", 64'(read_valid[1]), 64'd0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
    @(negedge clock); #1;
    checkOutput("t4_levels_refilled", 64'(level), 64'h924);

    // Drain channel 3, then hold the source not-ready for five cycles
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
    @(negedge clock); #1;
    checkOutput("t5_ch3_drained", 64'(level), 64'h124);
    ub = m_under;
    applyStimulus(1'b1, 4'b1000, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #1;
      checkOutput($sformatf("t5_fill_valid_%0d", i), 64'(fill_valid), 64'd1);
      checkOutput($sformatf("t5_fill_chan_%0d", i), 64'(fill_chan), 64'd3);
      checkOutput($sformatf("t5_levels_%0d", i), 64'(level), 64'h124);
      if (i == 4) applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
      else        applyStimulus(1'b1, 4'b1000, 4'b0000, 1'b0);
    end
    @(negedge clock); #1;
    checkOutput("t5_underrun_plus5", 64'(underrun_count), 64'(ub + 32'd5));

    // Bring every queue to half full, then reset during a live handshake
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(1'b0, 4'b0111, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0111, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
    @(negedge clock); #1;
    checkOutput("t6_levels_half", 64'(level), 64'h492);
    checkOutput("t6_grant_pre", 64'(fill_chan), 64'd0);
    @(negedge clock); #1;
    checkOutput("t6_grant_rotated", 64'(fill_chan), 64'd1);
    reset = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    @(negedge clock); #1;
    checkOutput("t6_levels_reset", 64'(level), 64'd0);
    checkOutput("t6_valid_reset", 64'(read_valid), 64'd0);
    checkOutput("t6_underrun_reset", 64'(underrun_count), 64'd0);
    checkOutput("t6_fill_valid_post", 64'(fill_valid), 64'd1);
    checkOutput("t6_grant_post", 64'(fill_chan), 64'd0);

    // Concurrent push and pop on all channels
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
    @(negedge clock); #1;
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
